// File: rtl/sm_i2c_pkg.sv
// Shared types and defaults for the I2C target: FSM state encoding and the
// glitch-filter length used by both pad filters.
package sm_i2c_pkg;

    localparam int unsigned FILT_LEN_DEF = 3;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        TX,
        TX_ACK,
        WAIT
    } state_e;

endpackage

// File: rtl/sm_i2c_line_filter.sv
// Conditions one asynchronous I2C pad line: 2-flop synchronizer, N-sample
// glitch filter, and registered single-cycle rise/fall pulses.
module sm_i2c_line_filter
    import sm_i2c_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0]          sync_q;
    logic [FILT_LEN-1:0] hist_q;
    logic                level_q;
    logic                rise_q;
    logic                fall_q;
    logic                all_hi;
    logic                all_lo;

    assign all_hi = &hist_q;
    assign all_lo = ~|hist_q;

    // Everything presets high so an idle bus looks idle straight out of reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its source regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            hist_q  <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
            rise_q <= ~level_q & all_hi;
            fall_q <= level_q & all_lo;
            if (all_hi) begin
                level_q <= 1'b1;
            end else if (all_lo) begin
                level_q <= 1'b0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sm_i2c_target.sv
// I2C target with a register pointer and auto-incrementing reads/writes into a
// local byte bank. Open-drain: sda_oe only ever pulls SDA low.
module sm_i2c_target
    import sm_i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_strobe,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [7:0]        rd_data,
    output logic              busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    sm_i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .reset  (reset),
        .line_i (scl_in),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    sm_i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .reset  (reset),
        .line_i (sda_in),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    state_e            state_q;
    logic [3:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        tx_q;
    logic              rw_q;
    logic              got_ack_q;
    logic              sda_oe_q;
    logic              wr_strobe_q;
    logic [7:0]        wr_data_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic              busy_q;

    logic       start_det;
    logic       stop_det;
    logic [7:0] byte_in;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            got_ack_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_data_q   <= '0;
            reg_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state_q   <= ADDR;
                bit_cnt_q <= '0;
                busy_q    <= 1'b1;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, WAIT: begin
                    end
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift_q <= byte_in;
                            if (bit_cnt_q != 4'd7) begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end else begin
                                bit_cnt_q <= '0;
                                case (state_q)
                                    ADDR: begin
                                        if (byte_in[7:1] == TARGET_ADDR) begin
                                            rw_q    <= byte_in[0];
                                            state_q <= ADDR_ACK;
                                        end else begin
                                            state_q <= IDLE;
                                            busy_q  <= 1'b0;
                                        end
                                    end
                                    PTR: begin
                                        reg_addr_q <= byte_in[ADDR_W-1:0];
                                        state_q    <= PTR_ACK;
                                    end
                                    default: begin
                                        wr_data_q   <= byte_in;
                                        wr_strobe_q <= 1'b1;
                                        state_q     <= WDATA_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // First fall drives the ACK, second fall ends the ACK bit.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                if (state_q == ADDR_ACK && rw_q) begin
                                    tx_q     <= rd_data;
                                    sda_oe_q <= ~rd_data[7];
                                    state_q  <= TX;
                                end else if (state_q == ADDR_ACK) begin
                                    state_q <= PTR;
                                end else begin
                                    if (state_q == WDATA_ACK) begin
                                        reg_addr_q <= reg_addr_q + ADDR_W'(1);
                                    end
                                    state_q <= WDATA;
                                end
                            end
                        end
                    end
                    TX: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                got_ack_q <= 1'b0;
                                state_q   <= TX_ACK;
                            end else begin
                                tx_q     <= {tx_q[6:0], 1'b0};
                                sda_oe_q <= ~tx_q[6];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_lvl) begin
                                got_ack_q  <= 1'b1;
                                reg_addr_q <= reg_addr_q + ADDR_W'(1);
                            end else begin
                                state_q <= WAIT;
                            end
                        end else if (scl_fall && got_ack_q) begin
                            got_ack_q <= 1'b0;
                            tx_q      <= rd_data;
                            sda_oe_q  <= ~rd_data[7];
                            bit_cnt_q <= '0;
                            state_q   <= TX;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_data   = wr_data_q;
    assign reg_addr  = reg_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sm_i2c_target.sv
// Directed bench for sm_i2c_target: a bit-banged initiator on a wired-AND SDA
// line, a static register bank, and a log of write strobes.
module tb_sm_i2c_target;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] wr_data, rd_data;
    logic [2:0] reg_addr;
    logic [7:0] bank [8];

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    int oe_viol = 0;
    logic [2:0] st_addr [16];
    logic [7:0] st_data [16];
    logic oe_last = 1'b0;
    logic rst_last = 1'b1;

    assign sda_line = sda_drv & ~sda_oe;
    assign rd_data  = bank[reg_addr];

    always #5 clk = ~clk;

    sm_i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_drv),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_strobe(wr_strobe),
        .wr_data  (wr_data),
        .reg_addr (reg_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (wr_strobe && strobe_cnt < 16) begin
            st_addr[strobe_cnt] <= reg_addr;
            st_data[strobe_cnt] <= wr_data;
            strobe_cnt <= strobe_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (sda_oe !== oe_last && scl_drv && !rst_last) oe_viol <= oe_viol + 1;
        oe_last  <= sda_oe;
        rst_last <= reset;
    end

    task automatic wait_q(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_rstart;
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop;
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q(2);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    wait_q();
        scl_drv = 1'b1; wait_q(2);
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        b = sda_line;   wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        wait_q(2);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        checks++; if (reg_addr !== 3'd0) begin failures++; $display("FAIL reset_reg_addr: got %0d want 0", reg_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write;
        logic [3:0] ack;
        int n0;
        n0 = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack[0]);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
        send_byte(8'h02, ack[1]);
        send_byte(8'h5A, ack[2]);
        send_byte(8'hC3, ack[3]);
        bus_stop();
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL wr_acks: got %b want 0000", ack); end
        checks++; if (strobe_cnt !== n0 + 2) begin failures++; $display("FAIL wr_strobe_count: got %0d want %0d", strobe_cnt - n0, 2); end
        checks++; if (st_addr[n0] !== 3'd2 || st_data[n0] !== 8'h5A) begin failures++; $display("FAIL wr_first: got addr %0d data %h want addr 2 data 5a", st_addr[n0], st_data[n0]); end
        checks++; if (st_addr[n0+1] !== 3'd3 || st_data[n0+1] !== 8'hC3) begin failures++; $display("FAIL wr_second: got addr %0d data %h want addr 3 data c3", st_addr[n0+1], st_data[n0+1]); end
        checks++; if (reg_addr !== 3'd4) begin failures++; $display("FAIL wr_ptr_after: got %0d want 4", reg_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_read_wrap;
        logic [2:0] ack;
        logic [7:0] d0, d1;
        int n0;
        n0 = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack[0]);
        send_byte(8'h07, ack[1]);
        bus_stop();
        bus_start();
        send_byte(8'hA1, ack[2]);
        checks++; if (ack !== 3'b000) begin failures++; $display("FAIL rd_acks: got %b want 000", ack); end
        read_byte(1'b0, d0);
        checks++; if (d0 !== 8'h11) begin failures++; $display("FAIL rd_byte0: got %h want 11", d0); end
        checks++; if (reg_addr !== 3'd0) begin failures++; $display("FAIL rd_ptr_wrap: got %0d want 0", reg_addr); end
        read_byte(1'b1, d1);
        checks++; if (d1 !== 8'h22) begin failures++; $display("FAIL rd_byte1: got %h want 22", d1); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy_in_wait: got %b want 1", busy); end
        bus_stop();
        checks++; if (busy !== 1'b0 || strobe_cnt !== n0) begin failures++; $display("FAIL rd_after_stop: got busy %b strobes %0d want busy 0 strobes 0", busy, strobe_cnt - n0); end
    endtask

    task automatic test_wrong_addr;
        logic ack, dummy;
        int oe0, n0;
        oe0 = oe_cnt;
        n0 = strobe_cnt;
        bus_start();
        send_byte(8'hA2, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL na_ack: got %b want 1", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL na_busy: got %b want 0", busy); end
        send_byte(8'h5A, dummy);
        checks++; if (oe_cnt !== oe0) begin failures++; $display("FAIL na_never_drive: got %0d driven cycles want 0", oe_cnt - oe0); end
        checks++; if (strobe_cnt !== n0) begin failures++; $display("FAIL na_no_strobe: got %0d want 0", strobe_cnt - n0); end
        bus_stop();
    endtask

    task automatic test_random_read;
        logic [2:0] ack;
        logic [7:0] d;
        bus_start();
        send_byte(8'hA0, ack[0]);
        send_byte(8'h04, ack[1]);
        bus_rstart();
        send_byte(8'hA1, ack[2]);
        read_byte(1'b1, d);
        checks++; if (ack !== 3'b000) begin failures++; $display("FAIL rr_acks: got %b want 000", ack); end
        checks++; if (d !== 8'h96) begin failures++; $display("FAIL rr_byte: got %h want 96", d); end
        bus_stop();
        checks++; if (reg_addr !== 3'd4) begin failures++; $display("FAIL rr_ptr: got %0d want 4", reg_addr); end
    endtask

    task automatic test_glitch_and_stop;
        logic [1:0] ack;
        int n0;
        n0 = strobe_cnt;
        @(negedge clk) sda_drv = 1'b0;
        @(negedge clk) sda_drv = 1'b1;
        wait_q(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gl_false_start: got busy %b want 0", busy); end
        bus_start();
        send_byte(8'hA0, ack[0]);
        send_byte(8'h01, ack[1]);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        @(negedge clk) sda_drv = 1'b1;
        @(negedge clk) sda_drv = 1'b0;
        wait_q();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gl_false_stop: got busy %b want 1", busy); end
        scl_drv = 1'b0; wait_q();
        bus_stop();
        checks++; if (ack !== 2'b00) begin failures++; $display("FAIL gl_acks: got %b want 00", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gl_stop_mid_byte: got busy %b want 0", busy); end
        checks++; if (strobe_cnt !== n0) begin failures++; $display("FAIL gl_no_strobe: got %0d want 0", strobe_cnt - n0); end
        checks++; if (reg_addr !== 3'd1) begin failures++; $display("FAIL gl_ptr: got %0d want 1", reg_addr); end
    endtask

    task automatic test_reset_mid_tx;
        logic [5:0] ack;
        int n0;
        bus_start();
        send_byte(8'hA0, ack[0]);
        send_byte(8'h05, ack[1]);
        bus_rstart();
        send_byte(8'hA1, ack[2]);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rt_driving_zero: got %b want 1", sda_oe); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rt_release: got %b want 0", sda_oe); end
        reset = 1'b0;
        wait_q(4);
        checks++; if (busy !== 1'b0 || reg_addr !== 3'd0) begin failures++; $display("FAIL rt_state: got busy %b ptr %0d want busy 0 ptr 0", busy, reg_addr); end
        n0 = strobe_cnt;
        bus_start();
        send_byte(8'hA0, ack[3]);
        send_byte(8'h06, ack[4]);
        send_byte(8'h77, ack[5]);
        bus_stop();
        checks++; if (ack !== 6'b000000) begin failures++; $display("FAIL rt_acks: got %b want 000000", ack); end
        checks++; if (strobe_cnt !== n0 + 1 || st_addr[n0] !== 3'd6 || st_data[n0] !== 8'h77) begin failures++; $display("FAIL rt_write: got %0d strobes addr %0d data %h want 1 strobe addr 6 data 77", strobe_cnt - n0, st_addr[n0], st_data[n0]); end
        checks++; if (busy !== 1'b0 || reg_addr !== 3'd7) begin failures++; $display("FAIL rt_after: got busy %b ptr %0d want busy 0 ptr 7", busy, reg_addr); end
    endtask

    task automatic test_bus_rules;
        checks++; if (oe_viol !== 0) begin failures++; $display("FAIL sda_change_while_scl_high: got %0d want 0", oe_viol); end
    endtask

    initial begin
        bank[0] = 8'h22; bank[1] = 8'h3C; bank[2] = 8'h00; bank[3] = 8'h00;
        bank[4] = 8'h96; bank[5] = 8'h0F; bank[6] = 8'h00; bank[7] = 8'h11;
        test_reset();
        test_write();
        test_read_wrap();
        test_wrong_addr();
        test_random_read();
        test_glitch_and_stop();
        test_reset_mid_tx();
        test_bus_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
